// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the s_core pipeline hazard controller.
// Forward-select codes, controller FSM states, BHT counter helpers.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [1:0] BHT_INIT  = 2'b01;

    typedef enum logic [1:0] {
        S_SETUP   = 2'd0,
        S_RUN     = 2'd1,
        S_LDSTALL = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic redirect;
        logic redirect_sel;
    } hz_ctl_t;

    function automatic logic [1:0] fwd_sel(
        input logic       exm_wr,
        input logic [4:0] exm_rd,
        input logic       wb_wr,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        logic exm_hit;
        logic wb_hit;
        exm_hit = exm_wr && (exm_rd != 5'd0) && (exm_rd == rs);
        wb_hit  = wb_wr && (wb_rd != 5'd0) && (wb_rd == rs);
        if (exm_hit)
            return FWD_EXMEM;
        else if (wb_hit)
            return FWD_MEMWB;
        else
            return FWD_NONE;
    endfunction

    function automatic logic [1:0] bht_next(
        input logic [1:0] c,
        input logic       taken
    );
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_bht.sv
// Branch history table: array of 2-bit saturating counters.
// One read port (fetch PC) and one update port (resolved EX branch).
module branch_history_table
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int  ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [ENTRIES];

    // Counter array: weakly-not-taken on reset, saturating update on branch resolve
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= BHT_INIT;
        end else if (upd_en) begin
            ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_taken);
        end
    end

    // Read sees the pre-update value on a same-cycle collision
    assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage s_core pipeline.
// Optional dynamic prediction: define BHT_PREDICT_EN (else static not-taken).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             setup,
    input  logic [31:0]      if_pc,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use1,
    input  logic             if_id_use2,
    input  logic [4:0]       id_ex_rs1,
    input  logic [4:0]       id_ex_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_br_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pc,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_wr,
    input  logic [4:0]       mem_wb_rd,
    input  logic             mem_wb_wr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             redirect,
    output logic             redirect_sel,
    output logic             pred_taken,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t  state;
    state_t  state_nx;
    hz_ctl_t ctl;
    logic    stall_ev;
    logic    flush_ev;
    logic    mispredict;
    logic    load_use;
    logic    run_setup;
    logic    run_redir;
    logic    run_stall;
    logic    unused_ok;

    assign mispredict = ex_is_jump
                      | (ex_is_branch & (ex_br_taken != ex_pred_taken));

    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0)
                    && ((if_id_use1 && (id_ex_rd == if_id_rs1))
                     || (if_id_use2 && (id_ex_rd == if_id_rs2)));

    // One-hot view of the S_RUN priority chain: setup > mispredict > load-use
    assign run_setup = setup;
    assign run_redir = !setup && mispredict;
    assign run_stall = !setup && !mispredict && load_use;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_SETUP;
        else
            state <= state_nx;
    end

    // Next-state selection
    always_comb begin
        state_nx = state;
        unique case (state)
            S_SETUP:   state_nx = setup ? S_SETUP : S_RUN;
            S_RUN: begin
                unique case (1'b1)
                    run_setup: state_nx = S_SETUP;
                    run_redir: state_nx = S_FLUSH;
                    run_stall: state_nx = S_LDSTALL;
                    default:   state_nx = S_RUN;
                endcase
            end
            S_LDSTALL: state_nx = setup ? S_SETUP : S_RUN;
            S_FLUSH:   state_nx = setup ? S_SETUP : S_RUN;
            default:   state_nx = S_SETUP;
        endcase
    end

    // Pipeline controls and counter events from state and hazards
    always_comb begin
        ctl      = '0;
        stall_ev = 1'b0;
        flush_ev = 1'b0;
        if (!rst_n) begin
            ctl.pc_stall    = 1'b1;
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end else begin
            unique case (state)
                S_SETUP: begin
                    ctl.pc_stall    = 1'b1;
                    ctl.if_id_flush = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                end
                S_RUN: begin
                    unique case (1'b1)
                        run_redir: begin
                            ctl.redirect     = 1'b1;
                            ctl.redirect_sel = ex_is_jump | ex_br_taken;
                            ctl.if_id_flush  = 1'b1;
                            ctl.id_ex_flush  = 1'b1;
                            flush_ev         = 1'b1;
                        end
                        run_stall: begin
                            ctl.pc_stall    = 1'b1;
                            ctl.if_id_stall = 1'b1;
                            ctl.id_ex_flush = 1'b1;
                            stall_ev        = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_LDSTALL: ;
                S_FLUSH:   ctl.if_id_flush = 1'b1;
                default:   ;
            endcase
        end
    end

    assign pc_stall     = ctl.pc_stall;
    assign if_id_stall  = ctl.if_id_stall;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign redirect     = ctl.redirect;
    assign redirect_sel = ctl.redirect_sel;

    assign fwd_a = rst_n ? fwd_sel(ex_mem_wr, ex_mem_rd,
                                   mem_wb_wr, mem_wb_rd,
                                   id_ex_rs1) : FWD_NONE;
    assign fwd_b = rst_n ? fwd_sel(ex_mem_wr, ex_mem_rd,
                                   mem_wb_wr, mem_wb_rd,
                                   id_ex_rs2) : FWD_NONE;

    // Saturating stall / redirect event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ev && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

`ifdef BHT_PREDICT_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_taken  (pred_taken),
        .upd_en    (ex_is_branch),
        .upd_idx   (ex_pc[IDX_W+1:2]),
        .upd_taken (ex_br_taken)
    );

    assign unused_ok = ^{if_pc, ex_pc};
`else
    assign pred_taken = 1'b0;
    assign unused_ok  = ^{if_pc, ex_pc, BHT_ENTRIES[0]};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors queue expected
// controls/counters; a negedge monitor pops and compares every cycle.
module tb_pipe_hazard_ctrl;

    localparam int CW = 3;

`ifdef BHT_PREDICT_EN
    localparam logic [10:0] PB = 11'b0000001_00_00;
`else
    localparam logic [10:0] PB = 11'b0000000_00_00;
`endif

    localparam logic [10:0] C_NONE = 11'b0000000_00_00;
    localparam logic [10:0] C_FRZ  = 11'b1011000_00_00;
    localparam logic [10:0] C_LU   = 11'b1101000_00_00;
    localparam logic [10:0] C_FL   = 11'b0010000_00_00;
    localparam logic [10:0] C_RT   = 11'b0011110_00_00;
    localparam logic [10:0] C_RN   = 11'b0011100_00_00;

    logic          clk;
    logic          rst_n;
    logic          setup;
    logic [31:0]   if_pc;
    logic [4:0]    if_id_rs1;
    logic [4:0]    if_id_rs2;
    logic          if_id_use1;
    logic          if_id_use2;
    logic [4:0]    id_ex_rs1;
    logic [4:0]    id_ex_rs2;
    logic [4:0]    id_ex_rd;
    logic          id_ex_mem_read;
    logic          ex_is_branch;
    logic          ex_is_jump;
    logic          ex_br_taken;
    logic          ex_pred_taken;
    logic [31:0]   ex_pc;
    logic [4:0]    ex_mem_rd;
    logic          ex_mem_wr;
    logic [4:0]    mem_wb_rd;
    logic          mem_wb_wr;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          pc_stall;
    logic          if_id_stall;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          redirect;
    logic          redirect_sel;
    logic          pred_taken;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    typedef struct {
        string       tag;
        logic [10:0] ctl;
        int          sc;
        int          fc;
    } exp_t;

    exp_t        q[$];
    exp_t        m;
    logic [10:0] got;
    int          checks = 0;
    int          errors = 0;

    pipe_hazard_ctrl #(
        .BHT_ENTRIES (64),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .setup          (setup),
        .if_pc          (if_pc),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .if_id_use1     (if_id_use1),
        .if_id_use2     (if_id_use2),
        .id_ex_rs1      (id_ex_rs1),
        .id_ex_rs2      (id_ex_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_br_taken    (ex_br_taken),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pc          (ex_pc),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_wr      (ex_mem_wr),
        .mem_wb_rd      (mem_wb_rd),
        .mem_wb_wr      (mem_wb_wr),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .redirect       (redirect),
        .redirect_sel   (redirect_sel),
        .pred_taken     (pred_taken),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic idle();
        rst_n          = 1'b1;
        setup          = 1'b0;
        if_pc          = 32'h0000_0004;
        if_id_rs1      = '0;
        if_id_rs2      = '0;
        if_id_use1     = 1'b0;
        if_id_use2     = 1'b0;
        id_ex_rs1      = '0;
        id_ex_rs2      = '0;
        id_ex_rd       = '0;
        id_ex_mem_read = 1'b0;
        ex_is_branch   = 1'b0;
        ex_is_jump     = 1'b0;
        ex_br_taken    = 1'b0;
        ex_pred_taken  = 1'b0;
        ex_pc          = 32'h0000_0100;
        ex_mem_rd      = '0;
        ex_mem_wr      = 1'b0;
        mem_wb_rd      = '0;
        mem_wb_wr      = 1'b0;
    endtask

    task automatic ld_use();
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd5;
        if_id_rs1      = 5'd5;
        if_id_use1     = 1'b1;
    endtask

    task automatic vec(input string tag, input logic [10:0] ctl,
                       input int sc, input int fc);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.sc  = sc;
        e.fc  = fc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                m   = q.pop_front();
                got = {pc_stall, if_id_stall, if_id_flush, id_ex_flush,
                       redirect, redirect_sel, pred_taken, fwd_a, fwd_b};
                checks++;
                if (got !== m.ctl) begin
                    errors++;
                    $display("FAIL %s ctl got %b expected %b",
                             m.tag, got, m.ctl);
                end
                checks++;
                if (stall_cnt !== CW'(m.sc)) begin
                    errors++;
                    $display("FAIL %s stall_cnt got %0d expected %0d",
                             m.tag, stall_cnt, m.sc);
                end
                checks++;
                if (flush_cnt !== CW'(m.fc)) begin
                    errors++;
                    $display("FAIL %s flush_cnt got %0d expected %0d",
                             m.tag, flush_cnt, m.fc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        setup = 1'b1;
        ex_mem_rd = 5'd3;
        ex_mem_wr = 1'b1;
        id_ex_rs1 = 5'd3;
        @(posedge clk);
        #1;
        vec("rst0", C_FRZ, 0, 0);
        vec("rst1", C_FRZ, 0, 0);
        idle(); setup = 1'b1;
        vec("setup_hold", C_FRZ, 0, 0);
        setup = 1'b0;
        vec("setup_rel", C_FRZ, 0, 0);
        idle();
        vec("run_idle", C_NONE, 0, 0);

        idle(); ld_use();
        vec("ld_use_rs1", C_LU, 0, 0);
        idle();
        vec("ld_bubble", C_NONE, 1, 0);
        idle();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5;
        if_id_rs2 = 5'd5; if_id_use2 = 1'b1;
        vec("ld_use_rs2", C_LU, 1, 0);
        vec("ld_hold_bub", C_NONE, 2, 0);
        vec("ld_b2b", C_LU, 2, 0);
        idle();
        vec("ld_bub2", C_NONE, 3, 0);
        idle();
        id_ex_mem_read = 1'b1; if_id_use1 = 1'b1;
        vec("ld_rd0", C_NONE, 3, 0);
        idle();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7;
        vec("ld_nouse", C_NONE, 3, 0);

        idle();
        ex_mem_rd = 5'd3; ex_mem_wr = 1'b1;
        mem_wb_rd = 5'd3; mem_wb_wr = 1'b1;
        id_ex_rs1 = 5'd3; id_ex_rs2 = 5'd3;
        vec("fwd_exmem", 11'b0000000_10_10, 3, 0);
        ex_mem_wr = 1'b0; id_ex_rs2 = 5'd4;
        vec("fwd_memwb", 11'b0000000_01_00, 3, 0);
        idle();
        ex_mem_wr = 1'b1; mem_wb_wr = 1'b1;
        vec("fwd_x0", C_NONE, 3, 0);
        idle();
        ex_mem_rd = 5'd4; ex_mem_wr = 1'b1; id_ex_rs2 = 5'd4;
        mem_wb_rd = 5'd3; mem_wb_wr = 1'b1; id_ex_rs1 = 5'd3;
        vec("fwd_mix", 11'b0000000_01_10, 3, 0);

        idle(); ex_is_branch = 1'b1; ex_br_taken = 1'b1;
        vec("br_mis_t", C_RT, 3, 0);
        idle();
        vec("flush_cyc", C_FL, 3, 1);
        idle(); ex_is_branch = 1'b1;
        vec("br_ok_nt", C_NONE, 3, 1);
        ex_br_taken = 1'b1; ex_pred_taken = 1'b1;
        vec("br_ok_t", C_NONE, 3, 1);
        idle(); ex_is_branch = 1'b1; ex_pred_taken = 1'b1;
        vec("br_mis_nt", C_RN, 3, 1);
        idle();
        vec("flush_cyc2", C_FL, 3, 2);
        idle(); ex_is_jump = 1'b1;
        vec("jump", C_RT, 3, 2);
        idle();
        vec("flush_cyc3", C_FL, 3, 3);
        idle(); ld_use(); ex_is_branch = 1'b1; ex_br_taken = 1'b1;
        vec("mis_vs_lu", C_RT, 3, 3);
        idle();
        vec("flush_cyc4", C_FL, 3, 4);
        idle(); setup = 1'b1; ex_is_jump = 1'b1;
        vec("setup_vs_mis", C_NONE, 3, 4);
        idle(); setup = 1'b1;
        vec("setup_frz", C_FRZ, 3, 4);
        idle();
        vec("setup_rel2", C_FRZ, 3, 4);
        idle();
        vec("run_idle2", C_NONE, 3, 4);

        idle(); if_pc = 32'h40;
        vec("bht_init", C_NONE, 3, 4);
        ex_is_branch = 1'b1; ex_br_taken = 1'b1; ex_pc = 32'h40;
        vec("bht_t1", C_RT, 3, 4);
        idle(); if_pc = 32'h40;
        vec("bht_after1", C_FL | PB, 3, 5);
        ex_is_branch = 1'b1; ex_br_taken = 1'b1;
        ex_pred_taken = 1'b1; ex_pc = 32'h40;
        vec("bht_t2", C_NONE | PB, 3, 5);
        ex_br_taken = 1'b0; ex_pred_taken = 1'b0;
        vec("bht_nt1", C_NONE | PB, 3, 5);
        vec("bht_nt2", C_NONE | PB, 3, 5);
        vec("bht_nt3", C_NONE, 3, 5);
        vec("bht_nt4", C_NONE, 3, 5);
        ex_br_taken = 1'b1; ex_pred_taken = 1'b1;
        vec("bht_from00", C_NONE, 3, 5);
        idle(); if_pc = 32'h40;
        vec("bht_final", C_NONE, 3, 5);

        for (int i = 0; i < 6; i++) begin
            idle(); ld_use();
            vec("sat_stall", C_LU, sat(3 + i), 5);
            idle();
            vec("sat_bub", C_NONE, sat(4 + i), 5);
        end
        for (int i = 0; i < 3; i++) begin
            idle(); ex_is_jump = 1'b1;
            vec("sat_jump", C_RT, 7, sat(5 + i));
            idle();
            vec("sat_flush", C_FL, 7, sat(6 + i));
        end

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain queue got %0d entries expected 0",
                     q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
